// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// grant[0] = IF, grant[1] = DM; on a tie the port that did not win last time gets it.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       req_if,
  input  logic       req_dm,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // one-hot grant selection
  always_comb begin
    grant = 2'b00;
    if (req_if && req_dm) begin
      grant = (last_grant == PORT_IF) ? 2'b10 : 2'b01;
    end else if (req_if) begin
      grant = 2'b01;
    end else if (req_dm) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port 256x8 memory between instruction fetch and data access.
// One access every four cycles: accept (IDLE), strobe (ISSUE), capture (WAIT), respond (RESP).
//
// state | meaning
// IDLE  | ready offered to the arbitration winner; accept latches the request
// ISSUE | memory strobe driven from the latched request
// WAIT  | read data (or 0 for writes) captured into rsp_data
// RESP  | one-cycle response pulse to the granted port
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  input  logic              dm_req_valid,
  input  logic              dm_req_we,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic              last_grant;
  logic              req_port;
  logic              req_we;
  logic [1:0]        grant;
  logic              accept;
  logic              nxt_port;
  logic              nxt_we;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_wdata;

  rr_arb2 u_rr_arb2 (
    .req_if     (if_req_valid),
    .req_dm     (dm_req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // ready only in IDLE and never while reset is held
  assign if_req_ready = !reset && (state == IDLE) && grant[0];
  assign dm_req_ready = !reset && (state == IDLE) && grant[1];
  assign accept       = (if_req_valid && if_req_ready) || (dm_req_valid && dm_req_ready);

  // select the fields of the winning request; fetches are always reads with no data
  always_comb begin
    nxt_port  = PORT_IF;
    nxt_we    = 1'b0;
    nxt_addr  = if_req_addr;
    nxt_wdata = '0;
    if (grant[1]) begin
      nxt_port  = PORT_DM;
      nxt_we    = dm_req_we;
      nxt_addr  = dm_req_addr;
      nxt_wdata = dm_req_wdata;
    end
  end

  // sequencing FSM plus the port id / direction of the in-flight request
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_IF;
      req_port   <= PORT_IF;
      req_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_port   <= nxt_port;
            req_we     <= nxt_we;
            last_grant <= nxt_port;
            state      <= ISSUE;
          end
        end
        ISSUE:   state <= WAIT;
        WAIT:    state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // memory port registers: loaded on accept so they are live exactly in ISSUE,
  // and they hold the latched address/data for that cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if (state == IDLE && accept) begin
        mem_en    <= 1'b1;
        mem_we    <= nxt_we;
        mem_addr  <= nxt_addr;
        mem_wdata <= nxt_wdata;
      end
    end
  end

  // capture read data in WAIT and raise the one-cycle response for RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data     <= '0;
      if_rsp_valid <= 1'b0;
      dm_rsp_valid <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      dm_rsp_valid <= 1'b0;
      if (state == WAIT) begin
        rsp_data     <= req_we ? '0 : mem_rdata;
        if_rsp_valid <= (req_port == PORT_IF);
        dm_rsp_valid <= (req_port == PORT_DM);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x8 synchronous memory.
module tb_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       if_req_valid;
  logic [7:0] if_req_addr;
  logic       if_req_ready;
  logic       if_rsp_valid;
  logic       dm_req_valid;
  logic       dm_req_we;
  logic [7:0] dm_req_addr;
  logic [7:0] dm_req_wdata;
  logic       dm_req_ready;
  logic       dm_rsp_valid;
  logic [7:0] rsp_data;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .dm_req_valid (dm_req_valid),
    .dm_req_we    (dm_req_we),
    .dm_req_addr  (dm_req_addr),
    .dm_req_wdata (dm_req_wdata),
    .dm_req_ready (dm_req_ready),
    .dm_rsp_valid (dm_rsp_valid),
    .rsp_data     (rsp_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous memory: read data valid the cycle after mem_en
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // one full transaction on a single port, checking every phase
  task automatic run_txn(input logic port, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd);
    @(posedge clk); #1;
    if (port) begin
      dm_req_valid = 1'b1;
      dm_req_we    = we;
      dm_req_addr  = addr;
      dm_req_wdata = wdata;
    end else begin
      if_req_valid = 1'b1;
      if_req_addr  = addr;
    end
    @(negedge clk);
    chk("acc_rdy",       port ? dm_req_ready : if_req_ready, 8'd1);
    chk("acc_other_rdy", port ? if_req_ready : dm_req_ready, 8'd0);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    @(negedge clk);
    chk("iss_en",    mem_en, 8'd1);
    chk("iss_we",    mem_we, port ? we : 1'b0);
    chk("iss_addr",  mem_addr, addr);
    chk("iss_wdata", mem_wdata, port ? wdata : 8'h00);
    chk("iss_rdy",   if_req_ready | dm_req_ready, 8'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_en",    mem_en, 8'd0);
    chk("wait_we",    mem_we, 8'd0);
    chk("wait_addr",  mem_addr, 8'h00);
    chk("wait_wdata", mem_wdata, 8'h00);
    chk("wait_rsp",   if_rsp_valid | dm_rsp_valid, 8'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsp_if",   if_rsp_valid, port ? 1'b0 : 1'b1);
    chk("rsp_dm",   dm_rsp_valid, port ? 1'b1 : 1'b0);
    chk("rsp_data", rsp_data, we ? 8'h00 : exp_rd);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rsp", if_rsp_valid | dm_rsp_valid, 8'd0);
  endtask

  initial begin
    reset        = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = 8'h00;
    dm_req_valid = 1'b1;
    dm_req_we    = 1'b0;
    dm_req_addr  = 8'h00;
    dm_req_wdata = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_rdy",  if_req_ready, 8'd0);
    chk("rst_dm_rdy",  dm_req_ready, 8'd0);
    chk("rst_if_rsp",  if_rsp_valid, 8'd0);
    chk("rst_dm_rsp",  dm_rsp_valid, 8'd0);
    chk("rst_rdata",   rsp_data, 8'h00);
    chk("rst_mem_en",  mem_en, 8'd0);
    chk("rst_mem_we",  mem_we, 8'd0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_wd",  mem_wdata, 8'h00);
    @(posedge clk); #1;
    reset        = 1'b0;
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;

    // DM write then read back, IF read of preloaded data, top address
    run_txn(1'b1, 1'b1, 8'h10, 8'hA5, 8'h00);
    run_txn(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);
    run_txn(1'b1, 1'b1, 8'h00, 8'h3C, 8'h00);
    run_txn(1'b0, 1'b0, 8'h00, 8'h00, 8'h3C);
    run_txn(1'b1, 1'b1, 8'hFF, 8'h5A, 8'h00);
    run_txn(1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A);
    run_txn(1'b1, 1'b1, 8'h20, 8'h11, 8'h00);
    run_txn(1'b1, 1'b1, 8'h30, 8'h22, 8'h00);

    // both ports valid from reset release: DM, IF, DM, IF every 4 cycles
    @(posedge clk); #1;
    reset        = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = 8'h20;
    dm_req_valid = 1'b1;
    dm_req_we    = 1'b0;
    dm_req_addr  = 8'h30;
    dm_req_wdata = 8'h77;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      logic dm_win;
      dm_win = ((c / 4) % 2) == 0;
      @(negedge clk);
      chk("rr_both_rdy", if_req_ready & dm_req_ready, 8'd0);
      case (c % 4)
        0: begin
          chk("rr_dm_rdy", dm_req_ready, dm_win);
          chk("rr_if_rdy", if_req_ready, !dm_win);
        end
        1: begin
          chk("rr_mem_en",   mem_en, 8'd1);
          chk("rr_mem_we",   mem_we, 8'd0);
          chk("rr_mem_addr", mem_addr, dm_win ? 8'h30 : 8'h20);
          chk("rr_busy_rdy", if_req_ready | dm_req_ready, 8'd0);
        end
        2: chk("rr_wait_en", mem_en, 8'd0);
        default: begin
          chk("rr_dm_rsp", dm_rsp_valid, dm_win);
          chk("rr_if_rsp", if_rsp_valid, !dm_win);
          chk("rr_rdata",  rsp_data, dm_win ? 8'h22 : 8'h11);
        end
      endcase
      @(posedge clk); #1;
    end
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;

    // reset pulsed during WAIT of a DM read
    @(posedge clk); #1;
    dm_req_valid = 1'b1;
    dm_req_we    = 1'b0;
    dm_req_addr  = 8'h10;
    @(negedge clk);
    chk("rw_acc", dm_req_ready, 8'd1);
    @(posedge clk); #1;
    dm_req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset        = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr  = 8'h10;
    @(negedge clk);
    chk("rw_dm_rsp",   dm_rsp_valid, 8'd0);
    chk("rw_if_rsp",   if_rsp_valid, 8'd0);
    chk("rw_rdata",    rsp_data, 8'h00);
    chk("rw_mem_en",   mem_en, 8'd0);
    chk("rw_mem_addr", mem_addr, 8'h00);
    chk("rw_if_rdy",   if_req_ready, 8'd1);
    chk("rw_dm_rdy",   dm_req_ready, 8'd0);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(negedge clk);
    chk("rw_iss_en",   mem_en, 8'd1);
    chk("rw_iss_addr", mem_addr, 8'h10);
    chk("rw_iss_we",   mem_we, 8'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_wait_dm", dm_rsp_valid, 8'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_if_rsp2", if_rsp_valid, 8'd1);
    chk("rw_dm_rsp2", dm_rsp_valid, 8'd0);
    chk("rw_rdata2",  rsp_data, 8'hA5);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
